// File: rtl/cache_bus_pkg.sv
// Shared types and constants for the cache memory-bus arbiter.
// Holds FSM/owner encodings, burst geometry and the default timeout.
package cache_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BEAT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  localparam int BURST_LEN   = 4;
  localparam int LINE_BYTES  = 16;
  localparam int TIMEOUT_DEF = 255;

  localparam logic [1:0] LAST_BEAT = 2'(BURST_LEN - 1);

  function automatic logic [31:0] beat_addr(
    input logic [27:0] base,
    input logic [1:0]  beat
  );
    return {base, beat, 2'b00};
  endfunction

endpackage

// File: rtl/cache_bus_rr.sv
// Two-input requester selector for the cache bus arbiter.
// Round-robin by default; CACHE_ARB_DPRIO_EN gives the D port fixed priority.
module cache_bus_rr
  import cache_bus_pkg::*;
(
  input  logic CLK,
  input  logic nRESET,
  input  logic i_req_i,
  input  logic i_req_d,
  input  logic i_grant,
  output logic o_sel_d
);

`ifdef CACHE_ARB_DPRIO_EN

  logic w_unused;
  assign w_unused = &{1'b0, CLK, nRESET, i_req_i, i_grant};

  assign o_sel_d = i_req_d;

`else

  owner_t r_last;

  // Remember who was served most recently so a tie flips sides.
  always_ff @(posedge CLK) begin
    if (nRESET) begin
      r_last <= OWN_D;
    end else if (i_grant) begin
      r_last <= o_sel_d ? OWN_D : OWN_I;
    end
  end

  assign o_sel_d = i_req_d & (~i_req_i | (r_last == OWN_I));

`endif

endmodule

// File: rtl/cache_bus_arbiter.sv
// Shares one memory bus between I-cache fills and D-cache fill/write-back.
// Optional CACHE_ARB_DPRIO_EN: D port wins simultaneous requests.
module cache_bus_arbiter
  import cache_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic        CLK,
  input  logic        nRESET,
  input  logic        I_REQ,
  input  logic [31:0] I_ADDR,
  output logic        I_ACK,
  output logic        I_RVALID,
  output logic [31:0] I_RDATA,
  output logic        I_DONE,
  output logic        I_ERR,
  input  logic        D_REQ,
  input  logic        D_WE,
  input  logic [31:0] D_ADDR,
  input  logic [31:0] D_WDATA,
  output logic        D_WREADY,
  output logic        D_ACK,
  output logic        D_RVALID,
  output logic [31:0] D_RDATA,
  output logic        D_DONE,
  output logic        D_ERR,
  output logic        B_AS,
  output logic [31:0] B_ADDR,
  output logic        B_WE,
  output logic [31:0] B_WDATA,
  input  logic [31:0] B_RDATA,
  input  logic        B_ACK
);

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t      r_state;
  owner_t      r_own;
  logic [27:0] r_base;
  logic        r_we;
  logic [1:0]  r_beat;
  logic [7:0]  r_wait;
  logic        r_ack;
  logic        r_rvalid;
  logic [31:0] r_rdata;
  logic        r_err;

  logic w_any;
  logic w_grant;
  logic w_sel_d;
  logic w_beat;
  logic w_done;
  logic w_bus_ack;
  logic w_rd_ack;
  logic w_own_i;
  logic w_wr_beat;
  logic w_unused_addr;

  assign w_unused_addr = &{1'b0, I_ADDR[3:0], D_ADDR[3:0]};

  assign w_any     = I_REQ | D_REQ;
  assign w_grant   = (r_state == ST_IDLE) & w_any;
  assign w_beat    = (r_state == ST_BEAT);
  assign w_done    = (r_state == ST_DONE);
  assign w_bus_ack = w_beat & B_ACK;
  assign w_rd_ack  = w_bus_ack & ~r_we;
  assign w_own_i   = (r_own == OWN_I);
  assign w_wr_beat = w_beat & r_we;

  cache_bus_rr u_rr (
    .CLK     (CLK),
    .nRESET  (nRESET),
    .i_req_i (I_REQ),
    .i_req_d (D_REQ),
    .i_grant (w_grant),
    .o_sel_d (w_sel_d)
  );

  // Burst sequencer: grant, beat counting, wait-state timeout.
  always_ff @(posedge CLK) begin
    if (nRESET) begin
      r_state <= ST_IDLE;
      r_own   <= OWN_I;
      r_base  <= '0;
      r_we    <= 1'b0;
      r_beat  <= '0;
      r_wait  <= '0;
      r_err   <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          r_err <= 1'b0;
          if (w_any) begin
            r_state <= ST_BEAT;
            r_own   <= w_sel_d ? OWN_D : OWN_I;
            r_base  <= w_sel_d ? D_ADDR[31:4] : I_ADDR[31:4];
            r_we    <= w_sel_d & D_WE;
            r_beat  <= '0;
            r_wait  <= '0;
          end
        end
        ST_BEAT: begin
          if (B_ACK) begin
            r_beat <= r_beat + 2'd1;
            r_wait <= '0;
            if (r_beat == LAST_BEAT) begin
              r_state <= ST_DONE;
            end
          end else if (r_wait == WAIT_LAST) begin
            r_state <= ST_DONE;
            r_err   <= 1'b1;
          end else begin
            r_wait <= r_wait + 8'd1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Grant pulse and registered read-beat return.
  always_ff @(posedge CLK) begin
    if (nRESET) begin
      r_ack    <= 1'b0;
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_ack    <= w_grant;
      r_rvalid <= w_rd_ack;
      if (w_rd_ack) begin
        r_rdata <= B_RDATA;
      end
    end
  end

  assign I_ACK    = r_ack & w_own_i;
  assign D_ACK    = r_ack & ~w_own_i;
  assign I_RVALID = r_rvalid & w_own_i;
  assign D_RVALID = r_rvalid & ~w_own_i;
  assign I_RDATA  = I_RVALID ? r_rdata : '0;
  assign D_RDATA  = D_RVALID ? r_rdata : '0;
  assign I_DONE   = w_done & w_own_i;
  assign D_DONE   = w_done & ~w_own_i;
  assign I_ERR    = I_DONE & r_err;
  assign D_ERR    = D_DONE & r_err;

  assign D_WREADY = w_bus_ack & r_we;

  assign B_AS    = w_beat;
  assign B_ADDR  = w_beat ? beat_addr(r_base, r_beat) : '0;
  assign B_WE    = w_wr_beat;
  assign B_WDATA = w_wr_beat ? D_WDATA : '0;

endmodule

// File: tb/tb_cache_bus_arbiter.sv
// Self-checking bench for cache_bus_arbiter.
// Directed scenarios plus randomized bursts against a transaction-level model.
module tb_cache_bus_arbiter;

  localparam int TO = 4;

  logic        CLK;
  logic        nRESET;
  logic        I_REQ;
  logic [31:0] I_ADDR;
  logic        I_ACK;
  logic        I_RVALID;
  logic [31:0] I_RDATA;
  logic        I_DONE;
  logic        I_ERR;
  logic        D_REQ;
  logic        D_WE;
  logic [31:0] D_ADDR;
  logic [31:0] D_WDATA;
  logic        D_WREADY;
  logic        D_ACK;
  logic        D_RVALID;
  logic [31:0] D_RDATA;
  logic        D_DONE;
  logic        D_ERR;
  logic        B_AS;
  logic [31:0] B_ADDR;
  logic        B_WE;
  logic [31:0] B_WDATA;
  logic [31:0] B_RDATA;
  logic        B_ACK;

  logic [138:0] all_out;
  assign all_out = {I_ACK, I_RVALID, I_RDATA, I_DONE, I_ERR,
                    D_WREADY, D_ACK, D_RVALID, D_RDATA, D_DONE, D_ERR,
                    B_AS, B_ADDR, B_WE, B_WDATA};

  cache_bus_arbiter #(.TIMEOUT(TO)) dut (
    .CLK(CLK), .nRESET(nRESET),
    .I_REQ(I_REQ), .I_ADDR(I_ADDR), .I_ACK(I_ACK),
    .I_RVALID(I_RVALID), .I_RDATA(I_RDATA),
    .I_DONE(I_DONE), .I_ERR(I_ERR),
    .D_REQ(D_REQ), .D_WE(D_WE), .D_ADDR(D_ADDR),
    .D_WDATA(D_WDATA), .D_WREADY(D_WREADY), .D_ACK(D_ACK),
    .D_RVALID(D_RVALID), .D_RDATA(D_RDATA),
    .D_DONE(D_DONE), .D_ERR(D_ERR),
    .B_AS(B_AS), .B_ADDR(B_ADDR), .B_WE(B_WE),
    .B_WDATA(B_WDATA), .B_RDATA(B_RDATA), .B_ACK(B_ACK)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_chk;
  int n_fail;
  bit m_last_d;

  logic [31:0] g_addr[4];
  logic [31:0] g_bwd[4];
  logic [31:0] g_wd[4];
  logic [31:0] g_sent[$];
  logic [31:0] g_rv[$];
  int g_rv_i, g_rv_d, g_nack, g_acks, g_wr, g_wr_co;
  int g_done_cyc, g_last_ack, g_we_hi, g_as_cyc, g_wbeat;
  logic g_first_i, g_first_d, g_done_i, g_done_d, g_err;
  logic g_as_after, g_done_after;

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    nRESET = 1'b1;
    I_REQ = 0; D_REQ = 0; D_WE = 0; B_ACK = 0;
    cyc(); cyc();
    nRESET = 1'b0;
    m_last_d = 1'b1;
  endtask

  function automatic bit model_pick(input bit ri, input bit rd);
`ifdef CACHE_ARB_DPRIO_EN
    return rd;
`else
    if (ri && rd) return ~m_last_d;
    return rd;
`endif
  endfunction

  // Bus responder and monitor; starts in the cycle after the grant edge.
  task automatic serve(input int wmin, input int wmax,
                       input bit stall, input bit drop);
    int waited, tgt;
    bit fin;
    g_sent.delete(); g_rv.delete();
    g_rv_i = 0; g_rv_d = 0; g_nack = 0; g_acks = 0;
    g_wr = 0; g_wr_co = 0; g_we_hi = 0; g_as_cyc = 0;
    g_wbeat = 0; g_done_cyc = -1; g_last_ack = -1;
    g_done_i = 0; g_done_d = 0; g_err = 0;
    waited = 0;
    tgt = $urandom_range(wmax, wmin);
    fin = 0;
    for (int c = 0; c < 80 && !fin; c++) begin
      B_ACK = !(stall && g_nack >= 2) && (waited >= tgt);
      B_RDATA = $urandom;
      D_WDATA = g_wd[g_wbeat % 4];
      @(negedge CLK);
      if (c == 0) begin
        g_first_i = I_ACK;
        g_first_d = D_ACK;
      end
      if (I_ACK | D_ACK) g_acks++;
      if (I_RVALID) begin g_rv_i++; g_rv.push_back(I_RDATA); end
      if (D_RVALID) begin g_rv_d++; g_rv.push_back(D_RDATA); end
      if (B_AS) begin
        g_as_cyc++;
        if (B_WE) g_we_hi++;
      end
      if (D_WREADY) begin
        g_wr++;
        if (B_ACK) g_wr_co++;
        g_wbeat++;
      end
      if (I_DONE | D_DONE) begin
        g_done_cyc = c;
        g_done_i = I_DONE;
        g_done_d = D_DONE;
        g_err = I_ERR | D_ERR;
        fin = 1;
      end
      if (B_AS && B_ACK && g_nack < 4) begin
        g_addr[g_nack] = B_ADDR;
        g_bwd[g_nack] = B_WDATA;
        if (!B_WE) g_sent.push_back(B_RDATA);
        g_nack++;
        g_last_ack = c;
        waited = 0;
        tgt = $urandom_range(wmax, wmin);
      end else if (B_AS) begin
        waited++;
      end
      if (fin && drop) begin
        if (g_done_i) I_REQ = 0;
        if (g_done_d) D_REQ = 0;
      end
      cyc();
    end
    B_ACK = 0;
    @(negedge CLK);
    g_as_after = B_AS;
    g_done_after = I_DONE | D_DONE;
  endtask

  task automatic test_reset();
    nRESET = 1'b1;
    I_REQ = 1; D_REQ = 1; D_WE = 1; B_ACK = 1;
    D_WDATA = 32'hDEADBEEF; B_RDATA = 32'h12345678;
    I_ADDR = 32'h1000; D_ADDR = 32'h2000;
    cyc(); cyc();
    @(negedge CLK);
    n_chk++;
    if (all_out !== '0) begin
      n_fail++;
      $display("FAIL reset_outs got=%h want=0", all_out);
    end
    do_reset();
  endtask

  task automatic test_i_fill();
    do_reset();
    I_REQ = 1; I_ADDR = 32'h00012345;
    cyc();
    serve(0, 0, 0, 1);
    n_chk++;
    if ({g_first_i, g_first_d} !== 2'b10) begin
      n_fail++;
      $display("FAIL ifill_ack got=%b want=10", {g_first_i, g_first_d});
    end
    for (int k = 0; k < 4; k++) begin
      n_chk++;
      if (g_addr[k] !== 32'h00012340 + 32'(4 * k)) begin
        n_fail++;
        $display("FAIL ifill_addr%0d got=%h want=%h",
                 k, g_addr[k], 32'h00012340 + 32'(4 * k));
      end
    end
    n_chk++;
    if (g_rv_i !== 4 || g_rv_d !== 0) begin
      n_fail++;
      $display("FAIL ifill_rvcnt got=%0d/%0d want=4/0", g_rv_i, g_rv_d);
    end
    for (int k = 0; k < g_rv.size() && k < g_sent.size(); k++) begin
      n_chk++;
      if (g_rv[k] !== g_sent[k]) begin
        n_fail++;
        $display("FAIL ifill_data%0d got=%h want=%h", k, g_rv[k], g_sent[k]);
      end
    end
    n_chk++;
    if (g_done_cyc !== 4) begin
      n_fail++;
      $display("FAIL ifill_done_cyc got=%0d want=4", g_done_cyc);
    end
    n_chk++;
    if ({g_done_i, g_done_d, g_err} !== 3'b100) begin
      n_fail++;
      $display("FAIL ifill_done got=%b want=100",
               {g_done_i, g_done_d, g_err});
    end
    n_chk++;
    if ({g_as_after, g_done_after} !== 2'b00) begin
      n_fail++;
      $display("FAIL ifill_after got=%b want=00", {g_as_after, g_done_after});
    end
  endtask

  task automatic test_d_writeback();
    do_reset();
    for (int k = 0; k < 4; k++) g_wd[k] = $urandom;
    D_REQ = 1; D_WE = 1; D_ADDR = 32'h0000A010;
    cyc();
    serve(2, 2, 0, 1);
    D_WE = 0;
    n_chk++;
    if ({g_first_i, g_first_d} !== 2'b01) begin
      n_fail++;
      $display("FAIL wb_ack got=%b want=01", {g_first_i, g_first_d});
    end
    n_chk++;
    if (g_wr !== 4 || g_wr_co !== 4) begin
      n_fail++;
      $display("FAIL wb_wready got=%0d/%0d want=4/4", g_wr, g_wr_co);
    end
    n_chk++;
    if (g_as_cyc !== 12 || g_we_hi !== 12) begin
      n_fail++;
      $display("FAIL wb_we got=%0d/%0d want=12/12", g_as_cyc, g_we_hi);
    end
    for (int k = 0; k < 4; k++) begin
      n_chk++;
      if (g_addr[k] !== 32'h0000A010 + 32'(4 * k) || g_bwd[k] !== g_wd[k]) begin
        n_fail++;
        $display("FAIL wb_beat%0d got=%h/%h want=%h/%h", k, g_addr[k],
                 g_bwd[k], 32'h0000A010 + 32'(4 * k), g_wd[k]);
      end
    end
    n_chk++;
    if (g_done_cyc !== 12 || {g_done_d, g_err} !== 2'b10 || g_rv.size() != 0) begin
      n_fail++;
      $display("FAIL wb_done got=%0d/%b/%0d want=12/10/0", g_done_cyc,
               {g_done_d, g_err}, g_rv.size());
    end
  endtask

  task automatic test_tie();
    bit exp_d;
    do_reset();
    I_REQ = 1; D_REQ = 1; D_WE = 0;
    I_ADDR = $urandom; D_ADDR = $urandom;
    for (int n = 0; n < 4; n++) begin
      exp_d = model_pick(1'b1, 1'b1);
      m_last_d = exp_d;
      cyc();
      serve(0, 0, 0, 0);
      n_chk++;
      if ({g_first_i, g_first_d, g_done_i, g_done_d} !==
          {~exp_d, exp_d, ~exp_d, exp_d}) begin
        n_fail++;
        $display("FAIL tie%0d got=%b want=%b", n,
                 {g_first_i, g_first_d, g_done_i, g_done_d},
                 {~exp_d, exp_d, ~exp_d, exp_d});
      end
    end
    I_REQ = 0; D_REQ = 0;
    cyc();
  endtask

  task automatic test_timeout();
    bit exp_d;
    do_reset();
    D_REQ = 1; D_WE = 0; D_ADDR = $urandom;
    m_last_d = 1'b1;
    cyc();
    serve(0, 0, 1, 1);
    n_chk++;
    if ({g_done_i, g_done_d, g_err} !== 3'b011) begin
      n_fail++;
      $display("FAIL tmo_err got=%b want=011", {g_done_i, g_done_d, g_err});
    end
    n_chk++;
    if (g_last_ack !== 1 || g_done_cyc !== g_last_ack + TO + 1) begin
      n_fail++;
      $display("FAIL tmo_cyc got=%0d want=%0d", g_done_cyc, 1 + TO + 1);
    end
    n_chk++;
    if (g_as_after !== 1'b0 || g_rv_d !== 2) begin
      n_fail++;
      $display("FAIL tmo_after got=%b/%0d want=0/2", g_as_after, g_rv_d);
    end
    I_REQ = 1; D_REQ = 1; I_ADDR = $urandom;
    exp_d = model_pick(1'b1, 1'b1);
    m_last_d = exp_d;
    cyc();
    serve(0, 0, 0, 1);
    n_chk++;
    if ({g_first_i, g_first_d} !== {~exp_d, exp_d}) begin
      n_fail++;
      $display("FAIL tmo_next got=%b want=%b",
               {g_first_i, g_first_d}, {~exp_d, exp_d});
    end
    I_REQ = 0; D_REQ = 0;
    cyc();
  endtask

  task automatic test_reset_mid();
    logic [31:0] base;
    do_reset();
    I_REQ = 1; I_ADDR = $urandom;
    base = {I_ADDR[31:4], 4'h0};
    cyc();
    B_ACK = 1; B_RDATA = $urandom;
    cyc();
    cyc();
    nRESET = 1; I_REQ = 0; D_REQ = 1; D_WE = 0; D_ADDR = $urandom;
    @(negedge CLK);
    n_chk++;
    if ({B_AS, B_ADDR} !== {1'b1, base + 32'd8}) begin
      n_fail++;
      $display("FAIL rstmid_beat2 got=%b/%h want=1/%h", B_AS, B_ADDR, base + 32'd8);
    end
    cyc();
    nRESET = 0; B_ACK = 0;
    m_last_d = 1'b1;
    @(negedge CLK);
    n_chk++;
    if (all_out !== '0) begin
      n_fail++;
      $display("FAIL rstmid_outs got=%h want=0", all_out);
    end
    cyc();
    serve(0, 1, 0, 1);
    n_chk++;
    if ({g_first_i, g_first_d, g_done_i, g_done_d} !== 4'b0101) begin
      n_fail++;
      $display("FAIL rstmid_dgrant got=%b want=0101",
               {g_first_i, g_first_d, g_done_i, g_done_d});
    end
  endtask

  task automatic test_random();
    logic [1:0] r;
    logic [31:0] base;
    bit exp_d, exp_we;
    do_reset();
    for (int it = 0; it < 20; it++) begin
      r = 2'($urandom_range(3, 1));
      if (!I_REQ && r[0]) begin
        I_REQ = 1; I_ADDR = $urandom;
      end
      if (!D_REQ && r[1]) begin
        D_REQ = 1; D_ADDR = $urandom; D_WE = 1'($urandom);
        for (int k = 0; k < 4; k++) g_wd[k] = $urandom;
      end
      exp_d = model_pick(I_REQ, D_REQ);
      m_last_d = exp_d;
      exp_we = exp_d & D_WE;
      base = exp_d ? {D_ADDR[31:4], 4'h0} : {I_ADDR[31:4], 4'h0};
      cyc();
      serve(0, 3, 0, 1);
      n_chk++;
      if ({g_first_i, g_first_d, g_acks == 1} !== {~exp_d, exp_d, 1'b1}) begin
        n_fail++;
        $display("FAIL rnd%0d_grant got=%b/%0d want=%b", it,
                 {g_first_i, g_first_d}, g_acks, {~exp_d, exp_d});
      end
      n_chk++;
      if ({g_done_i, g_done_d, g_err} !== {~exp_d, exp_d, 1'b0}) begin
        n_fail++;
        $display("FAIL rnd%0d_done got=%b want=%b", it,
                 {g_done_i, g_done_d, g_err}, {~exp_d, exp_d, 1'b0});
      end
      n_chk++;
      if (g_nack !== 4 || g_done_cyc !== g_last_ack + 1 ||
          g_as_cyc !== g_last_ack + 1) begin
        n_fail++;
        $display("FAIL rnd%0d_len got=%0d/%0d/%0d want=4/%0d/%0d", it,
                 g_nack, g_done_cyc, g_as_cyc, g_last_ack + 1, g_last_ack + 1);
      end
      for (int k = 0; k < 4; k++) begin
        n_chk++;
        if (g_addr[k] !== base + 32'(4 * k)) begin
          n_fail++;
          $display("FAIL rnd%0d_addr%0d got=%h want=%h", it, k,
                   g_addr[k], base + 32'(4 * k));
        end
      end
      if (exp_we) begin
        n_chk++;
        if (g_wr !== 4 || g_wr_co !== 4 || g_we_hi !== g_as_cyc ||
            g_rv.size() != 0) begin
          n_fail++;
          $display("FAIL rnd%0d_wr got=%0d/%0d/%0d want=4/4/%0d", it,
                   g_wr, g_wr_co, g_we_hi, g_as_cyc);
        end
        for (int k = 0; k < 4; k++) begin
          n_chk++;
          if (g_bwd[k] !== g_wd[k]) begin
            n_fail++;
            $display("FAIL rnd%0d_wd%0d got=%h want=%h", it, k,
                     g_bwd[k], g_wd[k]);
          end
        end
      end else begin
        n_chk++;
        if ((exp_d ? g_rv_d : g_rv_i) !== 4 || g_rv.size() != 4 ||
            g_wr !== 0 || g_we_hi !== 0) begin
          n_fail++;
          $display("FAIL rnd%0d_rd got=%0d/%0d/%0d/%0d want=4/4/0/0", it,
                   g_rv_i, g_rv_d, g_wr, g_we_hi);
        end
        for (int k = 0; k < g_rv.size() && k < g_sent.size(); k++) begin
          n_chk++;
          if (g_rv[k] !== g_sent[k]) begin
            n_fail++;
            $display("FAIL rnd%0d_rd%0d got=%h want=%h", it, k,
                     g_rv[k], g_sent[k]);
          end
        end
      end
    end
    I_REQ = 0; D_REQ = 0;
    cyc();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0;
    n_fail = 0;
    m_last_d = 1'b1;
    nRESET = 1'b1;
    I_REQ = 0; D_REQ = 0; D_WE = 0; B_ACK = 0;
    I_ADDR = '0; D_ADDR = '0; D_WDATA = '0; B_RDATA = '0;
    for (int k = 0; k < 4; k++) g_wd[k] = '0;
    test_reset();
    test_i_fill();
    test_d_writeback();
    test_tie();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
